cond_exec_ctrl: RTL and testbench
=================================

# cond_exec_ctrl

Conditional-execution controller for the ARM core. It owns the architectural NZCV status register and evaluates each decode-stage instruction's 4-bit condition field against the correct flags, forwarding in-flight ALU flags to remove the one-cycle flag hazard. It drives pass/squash qualification into the execute stage and sequences the front-end flush after a taken branch. It sits between the ID/EXE pipeline register and the ALU flag outputs.

## Interface
- FLUSH_CYCLES, 2, flush-pulse length after a taken branch; legal range 1..7.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline hold; freezes ID→EXE advance, SR commit, flush counting and the squash counter.
- id_valid  in  1  ID holds a real instruction.
- id_cond  in  4  ARM condition field, bits [31:28].
- id_s  in  1  instruction updates flags (S bit).
- id_branch  in  1  instruction is B/BL.
- alu_nzcv  in  4  flags produced by the ALU for the instruction currently in EXE, ordered {N,Z,C,V}; must stay stable while stall is high.
- id_exec  out  1  combinational: ID instruction valid, not flushed, and condition passed.
- exe_valid  out  1  registered: EXE holds an instruction that passed its condition.
- exe_s  out  1  registered: that EXE instruction writes flags.
- flush  out  1  registered: squash IF/ID.
- sr  out  4  architectural NZCV.
- squash_cnt  out  16  saturating count of valid instructions that failed their condition.

## Operation
- Effective flags: eff = alu_nzcv when exe_valid & exe_s, otherwise sr.
- Condition table on eff {n,z,c,v}:
  - 0 EQ: z. 1 NE: !z. 2 CS: c. 3 CC: !c.
  - 4 MI: n. 5 PL: !n. 6 VS: v. 7 VC: !v.
  - 8 HI: c & !z. 9 LS: !c | z.
  - 10 GE: n==v. 11 LT: n!=v.
  - 12 GT: !z & (n==v). 13 LE: z | (n!=v).
  - 14 AL: 1. 15 (NV): 0.
- pass = table result. id_exec = id_valid & !flush & pass.
- When stall is low, each edge performs:
  - ID→EXE advance: exe_valid ← id_exec; exe_s ← id_exec & id_s.
  - SR commit: if exe_valid & exe_s then sr ← alu_nzcv. The commit and the advance happen on the same edge, so back-to-back flag-setting instructions forward correctly.
  - Squash count: if id_valid & !flush & !pass, squash_cnt increments, saturating at 16'hFFFF.
- Flush FSM, states IDLE and FLUSH, with a 3-bit counter cnt:
  - IDLE → FLUSH when !stall & id_exec & id_branch; cnt ← FLUSH_CYCLES.
  - In FLUSH with !stall: cnt decrements; FLUSH → IDLE when cnt reaches 0 (the decrement from 1).
  - flush = (state == FLUSH).
  - Instructions in ID during FLUSH are squashed. They do not count in squash_cnt and cannot start a new flush.
- stall high: all registers hold, including cnt, state, sr and squash_cnt. id_exec remains combinational.
- A failed-condition branch produces no flush and increments squash_cnt.

## Timing
- id_exec: zero latency from id_* / alu_nzcv / sr.
- Flag visibility:
  - Flags from the instruction in EXE at cycle N are visible to ID at cycle N via forwarding.
  - The same flags appear on sr from cycle N+1.
- Taken branch in ID at cycle N (no stall): flush is high for cycles N+1 .. N+FLUSH_CYCLES, then low. Each stalled cycle extends the flush by one.
- Reset (asynchronous, any time, including mid-flush): sr=0, exe_valid=0, exe_s=0, flush=0, state=IDLE, cnt=0, squash_cnt=0. On release, operation resumes on the first rising edge with rst high.

## Test plan
- Reset, then id_valid=1 with id_cond=0 (EQ) and sr=0 → id_exec=0 and squash_cnt=1. Then cond=14 → id_exec=1. Then cond=15 → id_exec=0.
- Forwarding: EXE holds an S instruction with alu_nzcv=4'b0100 while ID has cond=0 (EQ) and sr=0 → id_exec=1 in that cycle, and sr=4'b0100 on the next cycle.
- All 16 condition codes against flag sets 0000, 0100, 1001, 0011, 1010 → id_exec matches the table, in particular LE passes with z=1, and GT fails when n!=v.
- Taken branch with FLUSH_CYCLES=2 → flush high for exactly 2 cycles, and a following valid instruction in ID gives id_exec=0 during that window. Repeat with stall high for 1 cycle mid-flush → flush lasts 3 cycles.
- Stall with EXE holding an S instruction with alu_nzcv=4'b1111 → sr unchanged while stalled, and sr=4'b1111 on the first cycle after stall falls.
- Assert rst low mid-flush with sr=4'b1010 → flush=0, sr=0 and squash_cnt=0 immediately, without waiting for a clock edge. Separately, preload squash_cnt to 16'hFFFF and force one more failure → the count stays at 16'hFFFF.

Source files
------------

// File: rtl/cond_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cond_exec_ctrl_if
//  Description : Bundle of decode-stage, ALU-flag and pipeline-control signals
//                exchanged between the pipeline and the conditional-execution
//                controller.
//                master : pipeline side (drives ID fields, stall, ALU flags)
//                slave  : controller side (drives exec qualification, flush,
//                         architectural flags and squash statistics)
//  Ports       : stall, id_valid, id_cond[3:0], id_s, id_branch,
//                alu_nzcv[3:0]                         (master -> slave)
//                id_exec, exe_valid, exe_s, flush, sr[3:0],
//                squash_cnt[15:0]                      (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface cond_exec_ctrl_if;
    logic        stall;
    logic        id_valid;
    logic [3:0]  id_cond;
    logic        id_s;
    logic        id_branch;
    logic [3:0]  alu_nzcv;

    logic        id_exec;
    logic        exe_valid;
    logic        exe_s;
    logic        flush;
    logic [3:0]  sr;
    logic [15:0] squash_cnt;

    modport master (
        output stall, id_valid, id_cond, id_s, id_branch, alu_nzcv,
        input  id_exec, exe_valid, exe_s, flush, sr, squash_cnt
    );

    modport slave (
        input  stall, id_valid, id_cond, id_s, id_branch, alu_nzcv,
        output id_exec, exe_valid, exe_s, flush, sr, squash_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cond_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cond_exec_ctrl
//  Description : Conditional-execution controller. Holds the architectural
//                NZCV register, evaluates the decode-stage condition field
//                against forwarded flags, qualifies the ID->EXE advance,
//                counts condition-failed instructions and sequences the
//                front-end flush that follows a taken branch.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active low
//                bus  - cond_exec_ctrl_if.slave (pipeline handshake/flags)
//  Parameters  : FLUSH_CYCLES - flush pulse length after a taken branch (1..7)
//  Revision    : 1.0  initial release
// ============================================================================
module cond_exec_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    cond_exec_ctrl_if.slave   bus
);

    localparam logic [2:0]  c_flush_init = 3'(FLUSH_CYCLES);
    localparam logic [15:0] c_sq_max     = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  sr_q, sr_d;
    logic        exe_valid_q, exe_valid_d;
    logic        exe_s_q, exe_s_d;
    logic [15:0] squash_cnt_q, squash_cnt_d;

    logic [3:0]  w_eff;
    logic        w_n, w_z, w_c, w_v;
    logic        w_pass;
    logic        w_flush;
    logic        w_id_exec;

    // The instruction sitting in EXE has not committed its flags yet; when it
    // is a flag setter its ALU result is the one ID must see this cycle.
    assign w_eff = (exe_valid_q && exe_s_q) ? bus.alu_nzcv : sr_q;
    assign w_n   = w_eff[3];
    assign w_z   = w_eff[2];
    assign w_c   = w_eff[1];
    assign w_v   = w_eff[0];

    always_comb begin
        w_pass = 1'b0;
        case (bus.id_cond)
            4'd0:    w_pass = w_z;
            4'd1:    w_pass = !w_z;
            4'd2:    w_pass = w_c;
            4'd3:    w_pass = !w_c;
            4'd4:    w_pass = w_n;
            4'd5:    w_pass = !w_n;
            4'd6:    w_pass = w_v;
            4'd7:    w_pass = !w_v;
            4'd8:    w_pass = w_c && !w_z;
            4'd9:    w_pass = !w_c || w_z;
            4'd10:   w_pass = (w_n == w_v);
            4'd11:   w_pass = (w_n != w_v);
            4'd12:   w_pass = !w_z && (w_n == w_v);
            4'd13:   w_pass = w_z || (w_n != w_v);
            4'd14:   w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    assign w_flush   = (state_q == ST_FLUSH);
    assign w_id_exec = bus.id_valid && !w_flush && w_pass;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        exe_valid_d  = exe_valid_q;
        exe_s_d      = exe_s_q;
        squash_cnt_d = squash_cnt_q;

        if (!bus.stall) begin
            exe_valid_d = w_id_exec;
            exe_s_d     = w_id_exec && bus.id_s;

            // Commit on the same edge as the advance, so a following flag
            // setter entering EXE never races the committing one.
            if (exe_valid_q && exe_s_q) begin
                sr_d = bus.alu_nzcv;
            end

            // Instructions squashed by a flush are not condition failures.
            if (bus.id_valid && !w_flush && !w_pass && (squash_cnt_q != c_sq_max)) begin
                squash_cnt_d = squash_cnt_q + 16'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_id_exec && bus.id_branch) begin
                        state_d = ST_FLUSH;
                        cnt_d   = c_flush_init;
                    end
                end
                ST_FLUSH: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            sr_q         <= 4'd0;
            exe_valid_q  <= 1'b0;
            exe_s_q      <= 1'b0;
            squash_cnt_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            exe_valid_q  <= exe_valid_d;
            exe_s_q      <= exe_s_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign bus.id_exec    = w_id_exec;
    assign bus.exe_valid  = exe_valid_q;
    assign bus.exe_s      = exe_s_q;
    assign bus.flush      = w_flush;
    assign bus.sr         = sr_q;
    assign bus.squash_cnt = squash_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cond_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cond_exec_ctrl
//  Description : Self-checking bench for cond_exec_ctrl. A driver issues one
//                decode-stage slot per cycle and pushes the expected outputs
//                from a behavioural model; a monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cond_exec_ctrl;

    localparam int FLUSH_CYCLES = 2;

    logic clk;
    logic rst;

    cond_exec_ctrl_if bus ();

    cond_exec_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id_exec;
        logic [3:0]  sr;
        logic        flush;
        logic        ev;
        logic        es;
        logic [15:0] sq;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    logic [3:0] m_sr;
    bit         m_ev, m_es;
    int         m_flush_left;
    int         m_sq;

    logic [3:0] prev_alu;
    bit         prev_stall;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
    endtask

    // ARM-style evaluation: even codes give the base test, odd codes invert it.
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic cyc(input bit v, input logic [3:0] c, input bit s, input bit br,
                       input logic [3:0] alu, input bit st);
        logic [3:0] eff;
        bit         flushing, pass, ex;
        exp_t       e;
        @(negedge clk);
        bus.id_valid  = v;
        bus.id_cond   = c;
        bus.id_s      = s;
        bus.id_branch = br;
        bus.alu_nzcv  = alu;
        bus.stall     = st;

        eff      = (m_ev && m_es) ? alu : m_sr;
        flushing = (m_flush_left > 0);
        pass     = ref_pass(c, eff);
        ex       = v && !flushing && pass;

        e.id_exec = ex;
        e.sr      = m_sr;
        e.flush   = flushing;
        e.ev      = m_ev;
        e.es      = m_es;
        e.sq      = 16'(m_sq);
        exp_q.push_back(e);

        if (!st) begin
            if (m_ev && m_es) m_sr = alu;
            m_ev = ex;
            m_es = ex && s;
            if (v && !flushing && !pass && m_sq < 65535) m_sq++;
            if (flushing) m_flush_left--;
            else if (ex && br) m_flush_left = FLUSH_CYCLES;
        end
        prev_alu   = alu;
        prev_stall = st;
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        bus.stall    = 1'b1;
        bus.id_valid = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("rst_flush",     16'(bus.flush),      16'd0);
        chk("rst_sr",        16'(bus.sr),         16'd0);
        chk("rst_squash",    bus.squash_cnt,      16'd0);
        chk("rst_exe_valid", 16'(bus.exe_valid),  16'd0);
        chk("rst_exe_s",     16'(bus.exe_s),      16'd0);
        m_sr = 4'd0; m_ev = 0; m_es = 0; m_flush_left = 0; m_sq = 0;
        @(negedge clk);
        #1 rst = 1'b1;
    endtask

    // Monitor: compares whatever the driver queued for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("id_exec",    16'(bus.id_exec),   16'(mon_e.id_exec));
                chk("sr",         16'(bus.sr),        16'(mon_e.sr));
                chk("flush",      16'(bus.flush),     16'(mon_e.flush));
                chk("exe_valid",  16'(bus.exe_valid), 16'(mon_e.ev));
                chk("exe_s",      16'(bus.exe_s),     16'(mon_e.es));
                chk("squash_cnt", bus.squash_cnt,     mon_e.sq);
            end
        end
    end

    initial begin
        logic [3:0] flagsets [5];
        logic [3:0] a;
        bit         st;
        flagsets = '{4'b0000, 4'b0100, 4'b1001, 4'b0011, 4'b1010};

        rst = 1'b0;
        bus.stall = 1'b1; bus.id_valid = 1'b0; bus.id_cond = 4'd0;
        bus.id_s = 1'b0; bus.id_branch = 1'b0; bus.alu_nzcv = 4'd0;
        m_sr = 4'd0; m_ev = 0; m_es = 0; m_flush_left = 0; m_sq = 0;
        prev_alu = 4'd0; prev_stall = 0;
        do_reset();

        // EQ fails on sr=0, then AL passes, then NV fails
        cyc(1, 4'd0,  0, 0, 4'd0, 0);
        cyc(1, 4'd14, 0, 0, 4'd0, 0);
        cyc(1, 4'd15, 0, 0, 4'd0, 0);
        cyc(0, 4'd0,  0, 0, 4'd0, 0);

        // Forwarding: S instruction in EXE produces Z; EQ in ID passes
        cyc(1, 4'd14, 1, 0, 4'd0,     0);
        cyc(1, 4'd0,  0, 0, 4'b0100,  0);
        cyc(0, 4'd0,  0, 0, 4'd0,     0);

        // Every condition code against each flag set
        foreach (flagsets[k]) begin
            cyc(1, 4'd14, 1, 0, 4'($urandom), 0);
            for (int c = 0; c < 16; c++)
                cyc(1, 4'(c), 0, 0, (c == 0) ? flagsets[k] : 4'($urandom), 0);
        end

        // Taken branch, valid instructions during the flush window
        cyc(1, 4'd14, 0, 1, 4'd0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 4'd14, 0, 1, 4'd0, 0);
        cyc(0, 4'd0, 0, 0, 4'd0, 0);
        // Same with one stalled cycle mid-flush
        cyc(1, 4'd14, 0, 1, 4'd0, 0);
        cyc(1, 4'd14, 0, 0, 4'd0, 0);
        cyc(1, 4'd14, 0, 0, 4'd0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 4'd14, 0, 0, 4'd0, 0);

        // Stall while an S instruction waits in EXE with 1111
        cyc(1, 4'd14, 1, 0, 4'd0,    0);
        cyc(1, 4'd14, 0, 0, 4'b1111, 1);
        cyc(1, 4'd14, 0, 0, 4'b1111, 1);
        cyc(1, 4'd14, 0, 0, 4'b1111, 0);
        cyc(0, 4'd0,  0, 0, 4'd0,    0);

        // Reset mid-flush with sr=1010
        cyc(1, 4'd15, 0, 0, 4'd0,    0);
        cyc(1, 4'd14, 1, 0, 4'd0,    0);
        cyc(1, 4'd14, 0, 1, 4'b1010, 0);
        cyc(1, 4'd14, 0, 0, 4'd0,    0);
        chk("pre_rst_sr", 16'(bus.sr), 16'(4'b1010));
        do_reset();

        // Randomized traffic; ALU flags held while the EXE instruction is stalled
        for (int i = 0; i < 1500; i++) begin
            st = ($urandom_range(0, 4) == 0);
            a  = (st || prev_stall) ? prev_alu : 4'($urandom);
            cyc($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom),
                $urandom_range(0, 5) == 0, a, st);
        end

        // Saturate the squash counter
        do_reset();
        for (int i = 0; i < 65540; i++) cyc(1, 4'd15, 0, 0, 4'd0, 0);
        cyc(0, 4'd0, 0, 0, 4'd0, 0);

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) chk("queue_drain", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
